// File: rtl/avalon_memtest_host_if.sv
// rtl/avalon_memtest_host_if.sv - Avalon-MM interface (avalon_if) used by the memory test host
interface avalon_if #(
    parameter int BURSTCOUNT_W = 4
);
    logic                    clk;
    logic                    reset;
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport host (
        input  clk, reset, readdata, readdatavalid, waitrequest,
        output address, read, write, writedata, byteenable, burstcount
    );

    modport agent (
        input  clk, reset, address, read, write, writedata, byteenable, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_memtest_host.sv
// rtl/avalon_memtest_host.sv - Avalon-MM write-then-verify memory test host
// MEMTEST_BURST_EN: defined = burst reads up to 2**(BURSTCOUNT_W-1) words, undefined = single reads
module avalon_memtest_host #(
    parameter int          ADDR_W       = 8,
    parameter int          BURSTCOUNT_W = 4,
    parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
    avalon_if.host              avalon_h,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-2:0]   nwords,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);
    localparam int MAX_BURST = 2 ** (BURSTCOUNT_W - 1);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, FIN} state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-2:0]       r_n;
    logic [ADDR_W-2:0]       r_wr_idx;
    logic [ADDR_W-2:0]       r_req_idx;
    logic [ADDR_W-2:0]       r_rd_idx;
    logic [BURSTCOUNT_W-1:0] r_beats_left;
    logic [ADDR_W-1:0]       r_addr;
    logic [31:0]             r_writedata;
    logic [BURSTCOUNT_W-1:0] r_burstcount;
    logic                    r_read;
    logic                    r_write;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [15:0]             r_err_count;
    logic [ADDR_W-1:0]       r_first_err_addr;

    logic [ADDR_W-2:0]       w_remaining;
    logic [BURSTCOUNT_W-1:0] w_len;

    // Byte address of word idx; the sum wraps modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-2:0] idx);
        return ADDR_W'(base + ADDR_W'({idx, 2'b00}));
    endfunction

    always_comb begin
        w_remaining = r_n - r_req_idx;
`ifdef MEMTEST_BURST_EN
        if (int'(w_remaining) > MAX_BURST) w_len = BURSTCOUNT_W'(MAX_BURST);
        else                               w_len = BURSTCOUNT_W'(w_remaining);
`else
        w_len = BURSTCOUNT_W'(1);
`endif
    end

    always_ff @(posedge avalon_h.clk) begin
        if (avalon_h.reset) begin
            r_state          <= IDLE;
            r_base           <= '0;
            r_n              <= '0;
            r_wr_idx         <= '0;
            r_req_idx        <= '0;
            r_rd_idx         <= '0;
            r_beats_left     <= '0;
            r_addr           <= '0;
            r_writedata      <= '0;
            r_burstcount     <= BURSTCOUNT_W'(1);
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: if (start) begin
                    r_busy           <= 1'b1;
                    r_pass           <= 1'b0;
                    r_err_count      <= '0;
                    r_first_err_addr <= '0;
                    r_base           <= base_addr & ~ADDR_W'(3);
                    r_n              <= nwords;
                    r_wr_idx         <= '0;
                    r_req_idx        <= '0;
                    r_rd_idx         <= '0;
                    if (nwords != '0) begin
                        r_state      <= WR;
                        r_write      <= 1'b1;
                        r_addr       <= base_addr & ~ADDR_W'(3);
                        r_writedata  <= SEED;
                        r_burstcount <= BURSTCOUNT_W'(1);
                    end else begin
                        r_state      <= FIN;
                    end
                end
                WR: if (!avalon_h.waitrequest) begin
                    if (r_wr_idx == r_n - (ADDR_W-1)'(1)) begin
                        // Last write accepted: issue the first read straight away.
                        r_write      <= 1'b0;
                        r_read       <= 1'b1;
                        r_addr       <= r_base;
                        r_burstcount <= w_len;
                        r_state      <= RD_REQ;
                    end else begin
                        r_wr_idx     <= r_wr_idx + (ADDR_W-1)'(1);
                        r_addr       <= word_addr(r_base, r_wr_idx + (ADDR_W-1)'(1));
                        r_writedata  <= SEED + 32'(r_wr_idx) + 32'd1;
                    end
                end
                RD_REQ: if (!avalon_h.waitrequest) begin
                    r_read       <= 1'b0;
                    r_beats_left <= r_burstcount;
                    r_req_idx    <= r_req_idx + (ADDR_W-1)'(r_burstcount);
                    r_state      <= RD_DATA;
                end
                RD_DATA: if (avalon_h.readdatavalid) begin
                    if (avalon_h.readdata != SEED + 32'(r_rd_idx)) begin
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        if (r_err_count == 16'd0)    r_first_err_addr <= word_addr(r_base, r_rd_idx);
                    end
                    r_rd_idx     <= r_rd_idx + (ADDR_W-1)'(1);
                    r_beats_left <= r_beats_left - BURSTCOUNT_W'(1);
                    if (r_beats_left == BURSTCOUNT_W'(1)) begin
                        if (w_remaining != '0) begin
                            r_read       <= 1'b1;
                            r_addr       <= word_addr(r_base, r_req_idx);
                            r_burstcount <= w_len;
                            r_state      <= RD_REQ;
                        end else begin
                            r_state      <= FIN;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_count == 16'd0);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign avalon_h.address    = 32'(r_addr);
    assign avalon_h.read       = r_read;
    assign avalon_h.write      = r_write;
    assign avalon_h.writedata  = r_writedata;
    assign avalon_h.byteenable = 4'hF;
    assign avalon_h.burstcount = r_burstcount;
    assign busy                = r_busy;
    assign done                = r_done;
    assign pass                = r_pass;
    assign err_count           = r_err_count;
    assign first_err_addr      = r_first_err_addr;
endmodule

// File: tb/tb_avalon_memtest_host.sv
// tb/tb_avalon_memtest_host.sv - self-checking bench for avalon_memtest_host with a BRAM agent model
module tb_avalon_memtest_host;
    localparam int          ADDR_W = 8;
    localparam int          BCW    = 4;
    localparam logic [31:0] SEED   = 32'hA5A5_0000;
`ifdef MEMTEST_BURST_EN
    localparam int MAXB = 8;
`else
    localparam int MAXB = 1;
`endif

    avalon_if #(.BURSTCOUNT_W(BCW)) av ();

    logic        start;
    logic [7:0]  base_addr;
    logic [6:0]  nwords;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  first_err_addr;

    avalon_memtest_host #(.ADDR_W(ADDR_W), .BURSTCOUNT_W(BCW), .SEED(SEED)) dut (
        .avalon_h       (av),
        .start          (start),
        .base_addr      (base_addr),
        .nwords         (nwords),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    initial av.clk = 1'b0;
    always #5 av.clk = ~av.clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // BRAM agent: 64 words, one cycle read latency, optional stalls and faults
    logic [31:0] mem [64];
    bit          fault [64];
    bit          stale_zero;
    int          stall_mode, stall_left, seen_14, both_high, hold_bad, done_cnt;
    bit          stall_done, prev_stall;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_bc;
    logic        p_rd, p_wr;
    int          beat_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];
    int          rd_len_q [$];

    always @(negedge av.clk) begin
        if (beat_q.size() > 0) begin
            int wa;
            wa = beat_q.pop_front();
            av.readdatavalid = 1'b1;
            av.readdata      = (fault[wa] || stale_zero) ? 32'h0 : mem[wa];
        end else begin
            av.readdatavalid = 1'b0;
            av.readdata      = $urandom;
        end
        if (done) done_cnt++;
        if (av.read && av.write) both_high++;
        if (prev_stall && !av.reset &&
            (av.address !== p_addr || av.writedata !== p_data || av.burstcount !== p_bc ||
             av.read !== p_rd || av.write !== p_wr)) hold_bad++;
        if (stall_mode == 2 && av.write && av.address == 32'h14) begin
            seen_14++;
            if (!stall_done) begin stall_left = 3; stall_done = 1; end
        end
        if (stall_left > 0) begin
            av.waitrequest = 1'b1;
            stall_left--;
        end else if (stall_mode == 1) av.waitrequest = ($urandom_range(0, 3) == 0);
        else av.waitrequest = 1'b0;
        prev_stall = !av.reset && (av.read || av.write) && av.waitrequest;
        p_addr = av.address; p_data = av.writedata; p_bc = av.burstcount;
        p_rd = av.read; p_wr = av.write;
        if (!av.reset && !av.waitrequest) begin
            if (av.write) begin
                mem[av.address[7:2]] = av.writedata;
                wr_addr_q.push_back(av.address);
                wr_data_q.push_back(av.writedata);
            end
            if (av.read) begin
                rd_addr_q.push_back(av.address);
                rd_len_q.push_back(int'(av.burstcount));
                for (int b = 0; b < int'(av.burstcount); b++)
                    beat_q.push_back((int'(av.address[7:2]) + b) % 64);
            end
        end
    end

    function automatic logic [31:0] exp_addr(input logic [7:0] b, input int i);
        logic [7:0] a;
        a = (b & 8'hFC) + 8'(4 * i);
        return 32'(a);
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_len_q.delete();
        both_high = 0; hold_bad = 0; seen_14 = 0; done_cnt = 0; stall_done = 0; stall_left = 0;
    endtask

    task automatic run_test(input string nm, input logic [7:0] b, input int n, input int smode,
                            input bit restart);
        logic [31:0] m [64];
        int lat, bad, errs, issued, r, len, k;
        logic [31:0] fa, rb;
        clear_logs();
        stall_mode = smode;
        @(negedge av.clk);
        start = 1'b1; base_addr = b; nwords = 7'(n);
        @(negedge av.clk);
        start = 1'b0;
        check_eq({nm, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        if (restart) begin
            start = 1'b1; base_addr = 8'h00; nwords = 7'h7F;
            @(negedge av.clk);
            start = 1'b0;
            lat = 1;
        end
        while (!done && lat < 3000) begin @(negedge av.clk); lat++; end
        check_eq({nm, "_done"}, 32'(done), 32'd1);
        if (n == 0) check_eq({nm, "_done_lat"}, 32'(lat), 32'd1);
        // Reference: ideal memory after all writes, then compare each word
        bad = 0;
        for (int i = 0; i < n; i++) begin
            m[exp_addr(b, i) >> 2] = SEED + 32'(i);
            if (i < wr_addr_q.size() &&
                (wr_addr_q[i] !== exp_addr(b, i) || wr_data_q[i] !== SEED + 32'(i))) bad++;
        end
        check_eq({nm, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'(n));
        check_eq({nm, "_wr_list"}, 32'(bad), 32'd0);
        errs = 0; fa = 32'h0;
        for (int i = 0; i < n; i++) begin
            k  = int'(exp_addr(b, i) >> 2);
            rb = fault[k] ? 32'h0 : m[k];
            if (rb != SEED + 32'(i)) begin
                if (errs == 0) fa = exp_addr(b, i);
                errs++;
            end
        end
        bad = 0; issued = 0; r = n; k = 0;
        while (r > 0) begin
            len = (r > MAXB) ? MAXB : r;
            if (k < rd_addr_q.size() && (rd_addr_q[k] !== exp_addr(b, issued) || rd_len_q[k] != len)) bad++;
            issued += len; r -= len; k++;
        end
        check_eq({nm, "_rd_cnt"}, 32'(rd_addr_q.size()), 32'(k));
        check_eq({nm, "_rd_list"}, 32'(bad), 32'd0);
        check_eq({nm, "_err_count"}, 32'(err_count), 32'(errs));
        check_eq({nm, "_first_err"}, 32'(first_err_addr), fa);
        check_eq({nm, "_pass"}, 32'(pass), 32'(errs == 0));
        check_eq({nm, "_rw_excl"}, 32'(both_high), 32'd0);
        check_eq({nm, "_hold"}, 32'(hold_bad), 32'd0);
        @(negedge av.clk);
        check_eq({nm, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({nm, "_busy_end"}, 32'(busy), 32'd0);
        @(negedge av.clk);
        check_eq({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        start = 1'b0; base_addr = '0; nwords = '0; av.reset = 1'b1;
        stall_mode = 0; stale_zero = 0;
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; fault[i] = 0; end
        clear_logs();
        repeat (3) @(negedge av.clk);
        check_eq("rst_read",   32'(av.read), 32'd0);
        check_eq("rst_write",  32'(av.write), 32'd0);
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_done",   32'(done), 32'd0);
        check_eq("rst_pass",   32'(pass), 32'd0);
        check_eq("rst_err",    32'(err_count), 32'd0);
        check_eq("rst_first",  32'(first_err_addr), 32'd0);
        check_eq("rst_addr",   av.address, 32'd0);
        check_eq("rst_wdata",  av.writedata, 32'd0);
        check_eq("rst_bc",     32'(av.burstcount), 32'd1);
        check_eq("rst_be",     32'(av.byteenable), 32'hF);
        av.reset = 1'b0;

        run_test("pass", 8'h10, 8, 0, 0);
        run_test("stall", 8'h10, 8, 2, 0);
        check_eq("stall_held", 32'(seen_14), 32'd4);
        fault[9] = 1;
        run_test("fault", 8'h10, 8, 0, 0);
        fault[9] = 0;
        run_test("burst", 8'h40, 20, 0, 0);
        run_test("zero", 8'h10, 0, 0, 0);

        // Abort during the read phase; queued beats come back as zeros and must be ignored
        clear_logs();
        stall_mode = 0;
        @(negedge av.clk);
        start = 1'b1; base_addr = 8'h10; nwords = 7'd8;
        @(negedge av.clk);
        start = 1'b0;
        k = 0;
        while (rd_addr_q.size() == 0 && k < 200) begin @(negedge av.clk); k++; end
        check_eq("abort_rd_seen", 32'(rd_addr_q.size() > 0), 32'd1);
        stale_zero = 1;
        @(negedge av.clk);
        av.reset = 1'b1; done_cnt = 0;
        repeat (2) @(negedge av.clk);
        av.reset = 1'b0;
        k = 0;
        while (beat_q.size() != 0 && k < 50) begin @(negedge av.clk); k++; end
        repeat (2) @(negedge av.clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_err",  32'(err_count), 32'd0);
        check_eq("abort_done", 32'(done_cnt), 32'd0);
        stale_zero = 0;
        run_test("rst_clean", 8'h10, 2, 0, 0);

        for (int t = 0; t < 8; t++) begin
            logic [7:0] b;
            int n;
            for (int i = 0; i < 64; i++) fault[i] = 0;
            for (int f = 0; f < int'($urandom_range(0, 2)); f++) fault[$urandom_range(0, 63)] = 1;
            b = 8'($urandom_range(0, 255));
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            run_test($sformatf("rnd%0d", t), b, n, 1, n >= 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/avalon_memtest_host.md
AVALON_MEMTEST_HOST -- requirements
Module: avalon_memtest_host

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the Avalon byte-address width.
REQ-002 The module SHALL have parameter BURSTCOUNT_W, default 4, meaning the burstcount width; the maximum burst is 2**(BURSTCOUNT_W-1) words.
REQ-003 The module SHALL have parameter SEED, default 32'hA5A5_0000, meaning the pattern base value.
REQ-004 The module SHALL use one clock, avalon_h.clk; reset is avalon_h.reset, synchronous and active-high.
REQ-005 The module SHALL have port avalon_h, an avalon_if.host interface port.
REQ-006 The avalon_h signals SHALL be, with direction from the host side:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- address  out  32  byte address, word aligned
- read  out  1  read request
- write  out  1  write request
- writedata  out  32  write data
- byteenable  out  4  always 4'hF
- burstcount  out  BURSTCOUNT_W  burst length
- readdata  in  32  read data
- readdatavalid  in  1  read data beat valid
- waitrequest  in  1  agent stall
REQ-007 The module SHALL have the following control ports:
- start  in  1  one-cycle pulse that launches a test
- base_addr  in  ADDR_W  first byte address, bits [1:0] ignored
- nwords  in  ADDR_W-1  word count N, where 0 means no transfer
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  last test had zero mismatches
- err_count  out  16  mismatches, saturating at 16'hFFFF
- first_err_addr  out  ADDR_W  byte address of the first mismatch

Function
REQ-008 The FSM states SHALL be IDLE, WR, RD_REQ, RD_DATA and FIN.
- IDLE to WR on start, when N is greater than 0.
- IDLE to FIN on start, when N is 0.
- WR to RD_REQ after the write of word N-1 is accepted.
- RD_REQ to RD_DATA when the read is accepted.
- RD_DATA to RD_REQ when the burst is complete and words remain.
- RD_DATA to FIN when the burst is complete and no words remain.
- FIN to IDLE unconditionally.
REQ-009 A command SHALL be accepted on a cycle where read or write is high and waitrequest is low; address, writedata, burstcount, read and write SHALL be held stable while waitrequest is high.
REQ-010 Word i (0..N-1) SHALL be written at address base_addr + 4*i, with writedata = SEED + i (32-bit wrap).
- One write is issued per accepted cycle.
- burstcount is 1 during writes.
- Back-to-back writes SHALL run with no idle cycle when waitrequest is low.
REQ-011 The read phase SHALL compare each readdatavalid beat with SEED + i.
- On mismatch, increment err_count (saturating).
- On the first mismatch, latch first_err_addr.
REQ-012 readdatavalid arriving outside RD_DATA SHALL be ignored.
REQ-013 Addresses SHALL wrap modulo 2**ADDR_W.
REQ-014 busy SHALL be high from the cycle after start until FIN, inclusive.
REQ-015 In FIN, done SHALL pulse for one cycle and pass SHALL be set to (err_count == 0).
REQ-016 start while busy SHALL be ignored.
REQ-017 At start, err_count SHALL be cleared, first_err_addr set to 0 and pass cleared.
REQ-018 read and write SHALL never be high in the same cycle.

Reset
REQ-019 Reset SHALL force the state to IDLE and all outputs to 0: read, write, busy, done, pass, err_count, first_err_addr, address and writedata.
- burstcount resets to 1.
- byteenable is always 4'hF.
REQ-020 Reset mid-test SHALL abort the test with no done pulse.
- Read data arriving after the reset is ignored.

Configuration
REQ-021 Macro MEMTEST_BURST_EN selects the read mode.
- Defined: each RD_REQ issues one read with burstcount = min(remaining, 2**(BURSTCOUNT_W-1)); RD_DATA collects exactly that many beats.
- Undefined: each RD_REQ issues a single read with burstcount = 1; RD_DATA waits for one beat.
- Write behaviour is identical in both modes.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Pass case, with the avalon_bram agent: base 0x10, N=8 -> addresses 0x10..0x2C written with A5A50000..A5A50007; done pulses; pass=1; err_count=0.
- Stall case: waitrequest high for 3 cycles on the 2nd write -> address 0x14 and data A5A50001 are held for 3 cycles; exactly 8 writes are accepted.
- Fault case: readdata forced to 0 on word 5, base 0x10 -> err_count=1; first_err_addr=0x24; pass=0.
- Burst case: N=20, MEMTEST_BURST_EN defined, BURSTCOUNT_W=4 -> read bursts of 8, 8, 4; N=20, macro undefined -> 20 single reads.
- Edge case: N=0 -> no read or write; done pulses 2 cycles after start; pass=1.
- Reset case: reset asserted during the read phase, then start with N=2 -> a clean test; pass=1; no stale beats are counted.
